// File: rtl/multdiv_ctrl_pkg.sv
// Shared definitions for the iterative multiply/divide unit: state encoding,
// default sizes and the most-negative 32-bit value.
package multdiv_ctrl_pkg;
    localparam int WIDTH_DEF = 32;
    localparam int ITERS_DEF = WIDTH_DEF;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;
endpackage

// File: rtl/is_not_zero.sv
// OR-tree zero detector: nz is high when any bit of value is set.
module is_not_zero #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    output logic             nz
);
    assign nz = |value;
endmodule

// File: rtl/multdiv_step.sv
// One iteration of the shared datapath: a single add/subtract feeding either
// a shift-add multiply step or a restoring-division step.
module multdiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] hi_next,
    output logic [WIDTH-1:0] lo_next
);
    logic [WIDTH:0] lhs;
    logic [WIDTH:0] rhs;
    logic [WIDTH:0] sum;

    // Operand select and the shared adder (subtract = add inverted plus one).
    always_comb begin
        if (is_div) begin
            lhs = {hi, lo[WIDTH-1]};
            rhs = {1'b0, opnd};
        end else begin
            lhs = {1'b0, hi};
            rhs = lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}};
        end
        sum = lhs + (is_div ? ~rhs : rhs) + {{WIDTH{1'b0}}, is_div};
    end

    // A borrow out of the subtraction means the trial remainder was too small.
    always_comb begin
        if (is_div) begin
            hi_next = sum[WIDTH] ? lhs[WIDTH-1:0] : sum[WIDTH-1:0];
            lo_next = {lo[WIDTH-2:0], ~sum[WIDTH]};
        end else begin
            hi_next = sum[WIDTH:1];
            lo_next = {sum[0], lo[WIDTH-1:1]};
        end
    end
endmodule

// File: rtl/multdiv_ctrl.sv
// Iterative signed multiply/divide unit with its sequencing FSM; the pipeline
// stalls until the one-cycle data_resultRDY pulse.
module multdiv_ctrl
    import multdiv_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int ITERS = WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);
    localparam int CW = $clog2(ITERS);
    localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

    state_t             state;
    logic [CW-1:0]      counter;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic [WIDTH-1:0]   opnd;
    logic               sign;
    logic               op_div;
    logic               div_zero;

    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               b_nz;
    logic [WIDTH-1:0]   hi_next;
    logic [WIDTH-1:0]   lo_next;
    logic [2*WIDTH-1:0] sprod;
    logic [WIDTH-1:0]   squot;
    logic [WIDTH-1:0]   fin_result;
    logic               fin_exc;

    // Magnitudes; the most-negative value maps onto its unsigned magnitude.
    assign mag_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign mag_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

    is_not_zero #(.WIDTH(WIDTH)) u_b_nz (
        .value (data_operandB),
        .nz    (b_nz)
    );

    multdiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (state == DIV),
        .hi      (hi),
        .lo      (lo),
        .opnd    (opnd),
        .hi_next (hi_next),
        .lo_next (lo_next)
    );

    // Final sign fix-up and exception decode presented to the DONE state.
    always_comb begin
        sprod      = {hi, lo};
        squot      = lo;
        fin_result = {WIDTH{1'b0}};
        fin_exc    = 1'b0;
        if (sign) begin
            sprod = -{hi, lo};
            squot = -lo;
        end else begin
            sprod = {hi, lo};
            squot = lo;
        end
        if (div_zero) begin
            fin_result = {WIDTH{1'b0}};
            fin_exc    = 1'b1;
        end else if (op_div) begin
            // Only INT_MIN / -1 yields a positive quotient with the top bit set.
            fin_result = squot;
            fin_exc    = ~sign & lo[WIDTH-1];
        end else begin
            fin_result = sprod[WIDTH-1:0];
            fin_exc    = ~((&sprod[2*WIDTH-1:WIDTH-1]) | ~(|sprod[2*WIDTH-1:WIDTH-1]));
        end
    end

    // Sequencer: start/abort handling, iteration, and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            counter        <= {CW{1'b0}};
            hi             <= {WIDTH{1'b0}};
            lo             <= {WIDTH{1'b0}};
            opnd           <= {WIDTH{1'b0}};
            sign           <= 1'b0;
            op_div         <= 1'b0;
            div_zero       <= 1'b0;
            data_result    <= {WIDTH{1'b0}};
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            if (state == DONE) begin
                data_resultRDY <= 1'b1;
                data_result    <= fin_result;
                data_exception <= fin_exc;
            end
            if (ctrl_MULT || ctrl_DIV) begin
                // A start in DONE keeps the exception of the result being reported.
                if (state != DONE) begin
                    data_exception <= 1'b0;
                end
                sign     <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                counter  <= {CW{1'b0}};
                hi       <= {WIDTH{1'b0}};
                div_zero <= 1'b0;
                if (ctrl_MULT) begin
                    state  <= MUL;
                    lo     <= mag_b;
                    opnd   <= mag_a;
                    op_div <= 1'b0;
                end else if (b_nz) begin
                    state  <= DIV;
                    lo     <= mag_a;
                    opnd   <= mag_b;
                    op_div <= 1'b1;
                end else begin
                    state    <= DONE;
                    op_div   <= 1'b1;
                    div_zero <= 1'b1;
                end
            end else begin
                case (state)
                    MUL, DIV: begin
                        hi      <= hi_next;
                        lo      <= lo_next;
                        counter <= counter + {{(CW-1){1'b0}}, 1'b1};
                        state   <= (counter == LAST) ? DONE : state;
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_multdiv_ctrl.sv
// Self-checking bench for multdiv_ctrl: a cycle-level arithmetic model checked
// every cycle, plus directed operations with literal expectations.
module tb_multdiv_ctrl;
    import multdiv_ctrl_pkg::*;

    logic        clock;
    logic        reset;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    int tests = 0;
    int fails = 0;

    // Model state
    bit          pend = 1'b0;
    int          cnt = 0;
    logic [31:0] pend_res = 32'd0;
    bit          pend_exc = 1'b0;
    logic [31:0] held_res = 32'd0;
    bit          held_exc = 1'b0;
    bit          rdy_exp = 1'b0;

    multdiv_ctrl dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (op_a),
        .data_operandB  (op_b),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Signed arithmetic reference: what the unit must report and when.
    function automatic void model_compute(input bit m, input bit d, input logic [31:0] a,
                                          input logic [31:0] b, output logic [31:0] r,
                                          output bit e, output int lat);
        longint p;
        int     q;
        lat = 33;
        if (m) begin
            p = longint'($signed(a)) * longint'($signed(b));
            r = p[31:0];
            e = (p > 64'sd2147483647) || (p < -64'sd2147483648);
        end else if (b == 32'd0) begin
            r = 32'd0;
            e = 1'b1;
            lat = 1;
        end else if (a == INT_MIN && b == 32'hFFFF_FFFF) begin
            r = INT_MIN;
            e = 1'b1;
        end else begin
            q = $signed(a) / $signed(b);
            r = q;
            e = 1'b0;
        end
        if (!m && !d) r = 32'd0;
    endfunction

    // Per-cycle model update and comparison.
    always @(posedge clock) begin
        logic [31:0] r;
        bit          e;
        int          lat;
        #1;
        if (reset) begin
            pend = 1'b0; held_res = 32'd0; held_exc = 1'b0; rdy_exp = 1'b0;
        end else begin
            rdy_exp = 1'b0;
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    rdy_exp = 1'b1; pend = 1'b0;
                    held_res = pend_res; held_exc = pend_exc;
                end
            end
            if (ctrl_MULT || ctrl_DIV) begin
                if (!rdy_exp) held_exc = 1'b0;
                model_compute(ctrl_MULT, ctrl_DIV, op_a, op_b, r, e, lat);
                pend = 1'b1; cnt = lat; pend_res = r; pend_exc = e;
            end
        end
        check("model_rdy", {63'd0, data_resultRDY}, {63'd0, rdy_exp});
        check("model_result", {32'd0, data_result}, {32'd0, held_res});
        check("model_exc", {63'd0, data_exception}, {63'd0, held_exc});
    end

    task automatic start_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        ctrl_MULT = m; ctrl_DIV = d; op_a = a; op_b = b;
        @(posedge clock);
        #2;
        ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    endtask

    task automatic wait_rdy(input int max, output int n);
        n = 0;
        for (int i = 0; i < max; i++) begin
            @(posedge clock);
            #2;
            n++;
            if (data_resultRDY) return;
        end
        n = -1;
    endtask

    task automatic directed(input string name, input bit m, input bit d, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] er, input bit ee, input int el);
        int n;
        start_op(m, d, a, b);
        wait_rdy(40, n);
        check({name, "_latency"}, 64'(n), 64'(el));
        check({name, "_result"}, {32'd0, data_result}, {32'd0, er});
        check({name, "_exc"}, {63'd0, data_exception}, {63'd0, ee});
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return INT_MIN;
            2: return 32'hFFFF_FFFF;
            3: return 32'h7FFF_FFFF;
            4: return 32'($urandom_range(0, 200)) - 32'd100;
            5: return 32'($urandom_range(0, 65535));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        int n;
        int rdy_seen;
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int rdy_seen;
        reset = 1'b1; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0; op_a = 32'd0; op_b = 32'd0;
        #1;
        check("reset_result", {32'd0, data_result}, 64'd0);
        check("reset_rdy", {63'd0, data_resultRDY}, 64'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        directed("mul_3_m7", 1'b1, 1'b0, 32'd3, 32'hFFFF_FFF9, 32'hFFFF_FFEB, 1'b0, 33);
        @(posedge clock); #2;
        check("mul_3_m7_rdy_drop", {63'd0, data_resultRDY}, 64'd0);
        directed("mul_ovf", 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, 33);
        directed("mul_max", 1'b1, 1'b0, 32'h7FFF_FFFF, 32'd1, 32'h7FFF_FFFF, 1'b0, 33);
        directed("div_100_m7", 1'b0, 1'b1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0, 33);
        directed("div_min_m1", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 33);
        directed("div_zero", 1'b0, 1'b1, 32'd5, 32'd0, 32'd0, 1'b1, 1);
        @(posedge clock); #2;
        check("div_zero_rdy_drop", {63'd0, data_resultRDY}, 64'd0);
        directed("both_start", 1'b1, 1'b1, 32'd2, 32'd3, 32'd6, 1'b0, 33);

        // Restart mid-multiply with a divide at edge 10.
        start_op(1'b1, 1'b0, 32'd6, 32'd7);
        repeat (9) @(posedge clock);
        directed("preempt", 1'b0, 1'b1, 32'd20, 32'd4, 32'd5, 1'b0, 33);

        // Asynchronous reset in the middle of a multiply.
        start_op(1'b1, 1'b0, 32'd9, 32'd9);
        repeat (14) @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        check("async_reset_result", {32'd0, data_result}, 64'd0);
        check("async_reset_rdy", {63'd0, data_resultRDY}, 64'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        rdy_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #2;
            if (data_resultRDY) rdy_seen++;
        end
        check("no_rdy_after_reset", 64'(rdy_seen), 64'd0);
        directed("mul_9_9", 1'b1, 1'b0, 32'd9, 32'd9, 32'd81, 1'b0, 33);

        // Random operations with random spacing, including restarts and DONE overlap.
        for (int k = 0; k < 60; k++) begin
            int gap;
            bit m;
            bit d;
            m = 1'($urandom_range(0, 1));
            d = m ? 1'($urandom_range(0, 1)) : 1'b1;
            start_op(m, d, rand_operand(), rand_operand());
            case ($urandom_range(0, 3))
                0: gap = 32;
                1: gap = $urandom_range(0, 31);
                default: gap = $urandom_range(33, 40);
            endcase
            repeat (gap) @(posedge clock);
        end
        repeat (40) @(posedge clock);
        #3;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
